ber_accum: RTL and testbench
============================

BER_ACCUM -- requirements
Module: ber_accum

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the checked word width in bits.
REQ-002 Parameter BIT_W, default 48, SHALL set the bit_cnt width.
REQ-003 Parameter ERR_W, default 32, SHALL set the err_cnt width.
REQ-004 Parameter LOSS_W, default 16, SHALL set the loss_cnt width.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-007 start  input  1  SHALL be a one-cycle pulse that clears the counters and arms a measurement.
REQ-008 stop  input  1  SHALL be a one-cycle pulse that ends a running measurement.
REQ-009 win_words  input  32  SHALL give the window length in words; 0 means unbounded.
REQ-010 lock  input  1  SHALL be the checker lock indication.
REQ-011 valid  input  1  SHALL qualify err_num for one WIDTH-bit word.
REQ-012 err_num  input  WIDTH+1  SHALL be the count of bit errors in the qualified word.
REQ-013 busy  output  1  SHALL be high in ARMED and RUN.
REQ-014 done  output  1  SHALL pulse high for exactly one cycle when a measurement ends.
REQ-015 bit_cnt  output  BIT_W  SHALL be the total counted bits.
REQ-016 err_cnt  output  ERR_W  SHALL be the total counted bit errors.
REQ-017 loss_cnt  output  LOSS_W  SHALL be the number of lock-loss events.
REQ-018 err_sat  output  1  SHALL be a sticky flag set when err_cnt saturates.

Function
REQ-019 The FSM SHALL have four states: IDLE, ARMED, RUN and DONE.
REQ-020 IDLE SHALL go to ARMED on start; all counters, word_cnt and err_sat clear on that edge.
REQ-021 ARMED SHALL go to RUN on the first cycle with lock=1; nothing is counted in ARMED.
REQ-022 RUN, when valid=1 and lock=1, SHALL add WIDTH to bit_cnt and err_num to err_cnt, and increment the internal 32-bit word_cnt.
REQ-023 err_num values greater than WIDTH SHALL be clamped to WIDTH before accumulation.
REQ-024 Counter outputs SHALL update one cycle after the sampled valid (registered, latency 1).
REQ-025 RUN with lock=0 SHALL increment loss_cnt once, go to ARMED, hold bit_cnt and err_cnt, and count no word in that cycle.
REQ-026 RUN SHALL go to DONE when win_words≠0 and word_cnt reaches win_words; the final word is included.
REQ-027 RUN or ARMED SHALL go to DONE on stop; a valid word in the stop cycle is still counted when in RUN.
REQ-028 DONE SHALL assert done for one cycle, return to IDLE the next cycle, and hold all counter values until the next start.
REQ-029 start in any state SHALL clear the counters and go to ARMED; start takes priority over stop, window end and lock loss in the same cycle.
REQ-030 bit_cnt, err_cnt and loss_cnt SHALL saturate at all-ones and never wrap.
REQ-031 err_sat SHALL set on the cycle err_cnt reaches all-ones and clear only on start or reset.
REQ-032 valid, lock and stop in IDLE or DONE SHALL have no effect.

Reset
REQ-033 reset low SHALL immediately force IDLE, with busy=0, done=0, bit_cnt=0, err_cnt=0, loss_cnt=0, err_sat=0 and word_cnt=0.
REQ-034 Reset asserted mid-measurement SHALL discard the measurement, and no done pulse SHALL follow.
REQ-035 After reset is released, the block SHALL remain in IDLE until start.

Verification
REQ-036 WIDTH=8, win_words=4, start, lock=1, four valid words with err_num 0,1,0,2 -> one done pulse; bit_cnt=32, err_cnt=3, loss_cnt=0.
REQ-037 win_words=0, start, 10 valid locked words, lock drops for 3 cycles, then 5 more words, then stop -> loss_cnt=1, bit_cnt=120, done pulses once.
REQ-038 err_num=15 on one valid word with WIDTH=8 -> err_cnt increases by 8.
REQ-039 ERR_W=4, every word err_num=8, run for 3 words -> err_cnt=15, err_sat=1, with no wrap.
REQ-040 start and stop pulsed in the same cycle during RUN -> counters cleared, state ARMED, no done pulse.
REQ-041 reset low during RUN after 6 words -> all outputs 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/ber_accum.sv
// Bit-error-rate accumulator: counts checked bits, bit errors and lock-loss
// events over a start/stop or fixed-length window of words.
module ber_accum #(
   parameter int WIDTH  = 8,
   parameter int BIT_W  = 48,
   parameter int ERR_W  = 32,
   parameter int LOSS_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [31:0]       win_words_i,
   input  logic              lock_i,
   input  logic              valid_i,
   input  logic [WIDTH:0]    err_num_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [BIT_W-1:0]  bit_cnt_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic [LOSS_W-1:0] loss_cnt_o,
   output logic              err_sat_o
);

   // Error sum is wide enough to hold the largest counter value plus one word.
   localparam int              EW_X      = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;
   localparam logic [WIDTH:0]  WORD_BITS = (WIDTH + 1)'(WIDTH);
   localparam logic [EW_X-1:0] ERR_MAX   = EW_X'({ERR_W{1'b1}});

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
   logic [31:0]         word_cnt_q, word_cnt_d;
   logic                err_sat_q, err_sat_d;

   logic [WIDTH:0]      err_clamp;
   logic [BIT_W:0]      bit_sum;
   logic [EW_X-1:0]     err_sum;
   logic [31:0]         word_inc;

   always_comb begin
      err_clamp = (err_num_i > WORD_BITS) ? WORD_BITS : err_num_i;
      bit_sum   = {1'b0, bit_cnt_q} + (BIT_W + 1)'(WIDTH);
      err_sum   = EW_X'(err_cnt_q) + EW_X'(err_clamp);
      word_inc  = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 32'd1;

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      err_cnt_d  = err_cnt_q;
      loss_cnt_d = loss_cnt_q;
      word_cnt_d = word_cnt_q;
      err_sat_d  = err_sat_q;

      if (start_i) begin
         state_d    = S_ARMED;
         bit_cnt_d  = '0;
         err_cnt_d  = '0;
         loss_cnt_d = '0;
         word_cnt_d = '0;
         err_sat_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ARMED: begin
               if (stop_i)      state_d = S_DONE;
               else if (lock_i) state_d = S_RUN;
            end
            S_RUN: begin
               if (!lock_i) begin
                  // Lock loss: count the event once and re-arm; this cycle's word is dropped.
                  if (!(&loss_cnt_q)) loss_cnt_d = loss_cnt_q + 1'b1;
                  state_d = stop_i ? S_DONE : S_ARMED;
               end else begin
                  if (valid_i) begin
                     bit_cnt_d  = bit_sum[BIT_W] ? '1 : bit_sum[BIT_W-1:0];
                     err_cnt_d  = (err_sum >= ERR_MAX) ? '1 : err_sum[ERR_W-1:0];
                     err_sat_d  = err_sat_q | (err_sum >= ERR_MAX);
                     word_cnt_d = word_inc;
                  end
                  if (stop_i || (valid_i && (win_words_i != 32'd0) && (word_inc >= win_words_i)))
                     state_d = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         err_cnt_q  <= '0;
         loss_cnt_q <= '0;
         word_cnt_q <= '0;
         err_sat_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         err_cnt_q  <= err_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         word_cnt_q <= word_cnt_d;
         err_sat_q  <= err_sat_d;
      end
   end

   assign busy_o     = (state_q == S_ARMED) || (state_q == S_RUN);
   assign done_o     = (state_q == S_DONE);
   assign bit_cnt_o  = bit_cnt_q;
   assign err_cnt_o  = err_cnt_q;
   assign loss_cnt_o = loss_cnt_q;
   assign err_sat_o  = err_sat_q;

endmodule

// File: tb/tb_ber_accum.sv
// Self-checking bench for ber_accum: directed table, multi-cycle sequences and
// randomized traffic against a behavioural model (default and ERR_W=4 instances).
module tb_ber_accum;

   localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
   localparam longint BMAX  = (64'd1 << 48) - 1;
   localparam longint EMAX  = 64'h0000_0000_FFFF_FFFF;
   localparam longint LMAX  = 65535;
   localparam longint E4MAX = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, lock, valid;
   logic [8:0]  err_num;
   logic [31:0] win_words;

   logic        busy, done, err_sat;
   logic [47:0] bit_cnt;
   logic [31:0] err_cnt;
   logic [15:0] loss_cnt;

   logic        s_busy, s_done, s_err_sat;
   logic [47:0] s_bit_cnt;
   logic [3:0]  s_err_cnt;
   logic [15:0] s_loss_cnt;

   ber_accum dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .win_words_i(win_words), .lock_i(lock), .valid_i(valid), .err_num_i(err_num),
      .busy_o(busy), .done_o(done), .bit_cnt_o(bit_cnt), .err_cnt_o(err_cnt),
      .loss_cnt_o(loss_cnt), .err_sat_o(err_sat)
   );

   ber_accum #(.ERR_W(4)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .win_words_i(win_words), .lock_i(lock), .valid_i(valid), .err_num_i(err_num),
      .busy_o(s_busy), .done_o(s_done), .bit_cnt_o(s_bit_cnt), .err_cnt_o(s_err_cnt),
      .loss_cnt_o(s_loss_cnt), .err_sat_o(s_err_sat)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int done_seen = 0;

   // Behavioural reference state
   int     m_st;
   longint m_bits, m_err, m_err4, m_loss, m_words;
   bit     m_sat, m_sat4;

   typedef struct {
      bit     st, sp, lk, vl;
      int     en, win;
      bit     busy, done;
      longint bits, errs, loss;
      bit     sat;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(int st, int sp, int lk, int vl, int en, int win,
                               int b, int d, longint bits, longint e, longint loss, int sat);
      vec_t v;
      v.st = st[0]; v.sp = sp[0]; v.lk = lk[0]; v.vl = vl[0];
      v.en = en; v.win = win; v.busy = b[0]; v.done = d[0];
      v.bits = bits; v.errs = e; v.loss = loss; v.sat = sat[0];
      return v;
   endfunction

   function automatic longint lmin(longint a, longint b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_bits = 0; m_err = 0; m_err4 = 0; m_loss = 0; m_words = 0;
      m_sat = 0; m_sat4 = 0;
   endtask

   task automatic model_update();
      longint e;
      if (start) begin
         model_reset();
         m_st = M_ARMED;
      end else if (m_st == M_ARMED) begin
         if (stop) m_st = M_DONE;
         else if (lock) m_st = M_RUN;
      end else if (m_st == M_RUN) begin
         if (!lock) begin
            m_loss = lmin(m_loss + 1, LMAX);
            m_st = stop ? M_DONE : M_ARMED;
         end else begin
            if (valid) begin
               e = (err_num > 8) ? 8 : longint'(err_num);
               m_bits = lmin(m_bits + 8, BMAX);
               m_err  = lmin(m_err + e, EMAX);
               m_err4 = lmin(m_err4 + e, E4MAX);
               if (m_err == EMAX) m_sat = 1;
               if (m_err4 == E4MAX) m_sat4 = 1;
               m_words++;
            end
            if (stop || (valid && win_words != 0 && m_words >= longint'(win_words)))
               m_st = M_DONE;
         end
      end else if (m_st == M_DONE) begin
         m_st = M_IDLE;
      end
   endtask

   task automatic check_model();
      chk("busy", longint'(busy), longint'(m_st == M_ARMED || m_st == M_RUN));
      chk("done", longint'(done), longint'(m_st == M_DONE));
      chk("bit_cnt", longint'(bit_cnt), m_bits);
      chk("err_cnt", longint'(err_cnt), m_err);
      chk("loss_cnt", longint'(loss_cnt), m_loss);
      chk("err_sat", longint'(err_sat), longint'(m_sat));
      chk("err_cnt_w4", longint'(s_err_cnt), m_err4);
      chk("err_sat_w4", longint'(s_err_sat), longint'(m_sat4));
   endtask

   task automatic step(input int st, input int sp, input int lk, input int vl,
                       input int en, input int win);
      start = st[0]; stop = sp[0]; lock = lk[0]; valid = vl[0];
      err_num = en[8:0]; win_words = win;
      @(posedge clk);
      model_update();
      #1;
      if (done) done_seen++;
      check_model();
      start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      rst_n = 1'b0; start = 0; stop = 0; lock = 0; valid = 0; err_num = 0; win_words = 0;
      model_reset();
      #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_bit_cnt", longint'(bit_cnt), 0);
      chk("rst_err_cnt", longint'(err_cnt), 0);
      chk("rst_loss_cnt", longint'(loss_cnt), 0);
      chk("rst_err_sat", longint'(err_sat), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // Traffic without start after reset must leave the block idle.
      repeat (4) step(0, 1, 1, 1, 3, 0);

      // Directed table: window of 4, clamp, lock loss, start+stop collision.
      //          st sp lk vl en win  busy done bits errs loss sat
      tbl[0]  = mk(1, 0, 0, 0, 0, 4,  1, 0,  0,  0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 1, 5, 4,  1, 0,  0,  0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 1, 0, 4,  1, 0,  8,  0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, 1, 4,  1, 0, 16,  1, 0, 0);
      tbl[4]  = mk(0, 0, 1, 1, 0, 4,  1, 0, 24,  1, 0, 0);
      tbl[5]  = mk(0, 0, 1, 1, 2, 4,  0, 1, 32,  3, 0, 0);
      tbl[6]  = mk(0, 0, 1, 1, 3, 4,  0, 0, 32,  3, 0, 0);
      tbl[7]  = mk(0, 1, 1, 1, 3, 4,  0, 0, 32,  3, 0, 0);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0,  1, 0,  0,  0, 0, 0);
      tbl[9]  = mk(0, 0, 1, 0, 0, 0,  1, 0,  0,  0, 0, 0);
      tbl[10] = mk(0, 0, 1, 1, 15, 0, 1, 0,  8,  8, 0, 0);
      tbl[11] = mk(0, 0, 1, 1, 9, 0,  1, 0, 16, 16, 0, 0);
      tbl[12] = mk(0, 0, 0, 1, 2, 0,  1, 0, 16, 16, 1, 0);
      tbl[13] = mk(0, 0, 0, 1, 3, 0,  1, 0, 16, 16, 1, 0);
      tbl[14] = mk(0, 0, 1, 0, 0, 0,  1, 0, 16, 16, 1, 0);
      tbl[15] = mk(0, 0, 1, 1, 4, 0,  1, 0, 24, 20, 1, 0);
      tbl[16] = mk(1, 1, 1, 1, 2, 0,  1, 0,  0,  0, 0, 0);
      tbl[17] = mk(0, 0, 0, 0, 0, 0,  1, 0,  0,  0, 0, 0);
      tbl[18] = mk(0, 1, 0, 0, 0, 0,  0, 1,  0,  0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].st, tbl[i].sp, tbl[i].lk, tbl[i].vl, tbl[i].en, tbl[i].win);
         chk($sformatf("tbl%0d_busy", i), longint'(busy), longint'(tbl[i].busy));
         chk($sformatf("tbl%0d_done", i), longint'(done), longint'(tbl[i].done));
         chk($sformatf("tbl%0d_bits", i), longint'(bit_cnt), tbl[i].bits);
         chk($sformatf("tbl%0d_errs", i), longint'(err_cnt), tbl[i].errs);
         chk($sformatf("tbl%0d_loss", i), longint'(loss_cnt), tbl[i].loss);
         chk($sformatf("tbl%0d_sat", i), longint'(err_sat), longint'(tbl[i].sat));
      end

      // Unbounded window with a 3-cycle lock drop, ended by stop.
      d0 = done_seen;
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1, i % 3, 0);
      repeat (3) step(0, 0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 0);
      step(0, 1, 1, 0, 0, 0);
      repeat (2) step(0, 0, 1, 1, 1, 0);
      chk("lossrun_bit_cnt", longint'(bit_cnt), 120);
      chk("lossrun_loss_cnt", longint'(loss_cnt), 1);
      chk("lossrun_done_pulses", longint'(done_seen - d0), 1);

      // Narrow error counter saturates without wrapping.
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      repeat (3) step(0, 0, 1, 1, 8, 0);
      chk("sat_w4_err_cnt", longint'(s_err_cnt), 15);
      chk("sat_w4_err_sat", longint'(s_err_sat), 1);
      chk("sat_full_err_cnt", longint'(err_cnt), 24);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a run.
      step(1, 0, 0, 0, 0, 10);
      step(0, 0, 1, 0, 0, 10);
      repeat (6) step(0, 0, 1, 1, 2, 10);
      d0 = done_seen;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_done", longint'(done), 0);
      chk("midrst_bit_cnt", longint'(bit_cnt), 0);
      chk("midrst_err_cnt", longint'(err_cnt), 0);
      chk("midrst_loss_cnt", longint'(loss_cnt), 0);
      chk("midrst_err_sat", longint'(err_sat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step(0, 0, 1, 1, 2, 10);
      chk("midrst_no_done", longint'(done_seen - d0), 0);
      chk("midrst_idle_busy", longint'(busy), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 39) == 0) ? 1 : 0,
              ($urandom_range(0, 29) == 0) ? 1 : 0,
              ($urandom_range(0, 9) != 0) ? 1 : 0,
              ($urandom_range(0, 9) < 7) ? 1 : 0,
              int'($urandom_range(0, 12)),
              int'($urandom_range(0, 6)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
